// File: rtl/irq_pending_ctrl_pkg.sv
// Shared widths and FSM encoding for the interrupt pending/service stage.
package irq_pending_ctrl_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        SETTLE  = 2'd2
    } state_t;

endpackage

// File: rtl/irq_pending_ctrl_encoder.sv
// 8-to-3 priority encoder: Y is the highest set index of X, NON flags an all-zero X.
module binary_priority_encoder
    import irq_pending_ctrl_pkg::*;
(
    output logic             NON,
    output logic [IDX_W-1:0] Y,
    input  logic [N_REQ-1:0] X
);

    // Ascending scan so the last (highest) set bit overrides lower ones.
    always_comb begin
        Y = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (X[i]) begin
                Y = IDX_W'(i);
            end
        end
    end

    assign NON = (X == '0);

endmodule

// File: rtl/irq_pending_ctrl.sv
// Captures request rising edges into a sticky pending register and serves them
// one at a time, highest index first, through a valid/ack handshake.
module irq_pending_ctrl
    import irq_pending_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic             enable,
    output logic             irq_valid,
    output logic [IDX_W-1:0] irq_id,
    input  logic             irq_ack,
    output logic [N_REQ-1:0] pending,
    output logic             none
);

    state_t           state;
    logic [N_REQ-1:0] req_d;
    logic [N_REQ-1:0] rise;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] masked;
    logic [IDX_W-1:0] enc_id;

    assign rise   = req & ~req_d;
    assign masked = pending & ~mask;

    // Only an ack seen while presenting may clear; the clear targets the latched id.
    always_comb begin
        clr = '0;
        if (state == PRESENT && irq_ack) begin
            clr = N_REQ'(1) << irq_id;
        end
    end

    binary_priority_encoder u_enc (
        .NON (none),
        .Y   (enc_id),
        .X   (masked)
    );

    // req_d loads req even in reset so a line held high across reset posts nothing.
    always_ff @(posedge clk) begin
        req_d <= req;
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr) | rise;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            irq_valid <= 1'b0;
            irq_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && !none) begin
                        irq_id    <= enc_id;
                        irq_valid <= 1'b1;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (irq_ack) begin
                        irq_valid <= 1'b0;
                        state     <= SETTLE;
                    end
                end
                // One quiet cycle so the cleared bit is gone before re-arbitrating.
                SETTLE: begin
                    state <= IDLE;
                end
                default: begin
                    irq_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/irq_pending_ctrl.md
Name: irq_pending_ctrl

Overview:
- Upstream request-capture and service stage for the 8-to-3 `binary_priority_encoder`.
- Each cycle it does three things:
  - captures rising edges on 8 request lines into a sticky pending register;
  - applies a mask;
  - feeds the masked vector to the encoder.
- It presents the winning index with a valid/ack handshake and clears the serviced bit on acknowledge.
- It sits between raw event sources and the consumer (CPU/sequencer) that services one event at a time.

Parameters:
- N_REQ, 8, number of request lines; fixed to match the 8-input encoder.
- IDX_W, 3, index width, equal to log2(N_REQ).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  raw request lines; a rising edge (0 then 1 on consecutive samples) posts an event.
- mask  input  8  1 blocks the corresponding pending bit from arbitration; the bit stays pending.
- enable  input  1  global arbitration enable.
- irq_valid  output  1  an event index is being presented.
- irq_id  output  3  index of the presented event; highest set index wins.
- irq_ack  input  1  consumer accepts the presented event.
- pending  output  8  current sticky pending register, unmasked view.
- none  output  1  1 when the masked pending vector is zero; this is the encoder's NON.

Behaviour:
- Reset:
  - pending, irq_valid and irq_id are 0; state is IDLE.
  - req_d (edge-detect register) loads the current value of req, so a line already high at reset release posts no event.
  - none is combinational and reads 1 after reset.
- Edge capture:
  - rise = req & ~req_d, evaluated every cycle in every state.
  - pending_next = (pending & ~clr) | rise.
  - If a set and a clear hit the same bit in the same cycle, the set wins and the bit re-pends.
- Arbitration:
  - masked = pending & ~mask, fed to the `binary_priority_encoder` instance.
  - Encoder outputs enc_id[2:0] = highest set bit index, and none.
- FSM states: IDLE, PRESENT, SETTLE.
  - IDLE: if enable && !none, latch irq_id <= enc_id and irq_valid <= 1, then go to PRESENT.
  - PRESENT:
    - irq_valid = 1 and irq_id is held stable regardless of mask, enable or new higher-priority rises; there is no preemption or withdrawal.
    - On irq_ack: clr = one-hot(irq_id), irq_valid <= 0, go to SETTLE.
  - SETTLE: one cycle with irq_valid = 0 while the cleared pending value propagates, then go to IDLE. This guarantees no back-to-back presentation of a stale index.
- Latency:
  - req first sampled high at edge k sets pending after edge k.
  - If IDLE, enabled and unmasked, irq_valid is high after edge k+1.
  - After irq_ack sampled at edge a, the next irq_valid can be high after edge a+2.
- irq_ack outside PRESENT is ignored; it produces no clear.
- All pending bits masked, or enable low: stay in IDLE; pending keeps accumulating.
- A bit already pending that rises again is absorbed; there is no event counting.
- Reset asserted mid-handshake: everything clears per the reset values on the next edge; the in-flight event is discarded.
- Width rules:
  - irq_id is exactly 3 bits.
  - One-hot clear is generated by shifting 8'b1 left by irq_id; no out-of-range index is possible.

Decomposition:
- Shared package/header:
  - N_REQ and IDX_W;
  - FSM state encodings: IDLE=2'd0, PRESENT=2'd1, SETTLE=2'd2.
- Sub-module: the existing `binary_priority_encoder`, instantiated once with port order (NON, Y, X):
  - NON to none;
  - Y to enc_id;
  - X to masked.
- Edge detect, pending register and FSM stay in this module.

Test Plan:
1. Reset with req=8'h04 held high, then release. Required: pending=8'h00, none=1, irq_valid stays 0 for 10 cycles.
2. Rise on req bit 5, mask=0, enable=1. Required: pending=8'h20 one edge later; irq_valid=1 and irq_id=5 one edge after that. Ack one cycle. Required: pending=8'h00, SETTLE cycle, then idle.
3. Rise on bits 1 and 6 in the same cycle. Required: irq_id=6 first; after ack and SETTLE, irq_id=1; after the second ack, none=1.
4. pending=8'h80 with mask=8'h80. Required: no irq_valid. Then mask=0. Required: irq_valid with irq_id=7 two cycles later. During PRESENT, set mask=8'hFF and post a rise on bit 3. Required: irq_id stays 7 until ack; bit 3 is presented next.
5. While presenting id=2, a new rise on bit 2 coincides with irq_ack. Required: pending[2] stays 1 and id=2 is presented again after SETTLE.
6. Assert rst during PRESENT. Required: next cycle irq_valid=0, pending=0, and an irq_ack pulse right after reset has no effect.
